arbitro_rr: RTL and testbench
=============================

Name: arbitro_rr

Overview:
- Round-robin scheduler between the four input virtual-channel FIFOs (fifo0..fifo3) and the four output FIFOs (fifo4..fifo7).
- Each cycle it picks at most one eligible input head word, pops it, and forwards it with a push to the output FIFO selected by the word's destination field.
- It honours output almost-full backpressure.
- It keeps per-input word counters that the bench can read through the req/idx interface.

Parameters:
- DATA_W, 10, word width: payload plus destination.
- DEST_LSB, 8, LSB of the 2-bit destination field, i.e. data[DEST_LSB+1:DEST_LSB].
- CNT_W, 5, width of each per-input word counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- init  in  1  synchronous soft-init: clears counters and the pointer, and blocks all pops while high.
- empty_in  in  4  empty flags of input FIFOs 0..3.
- data_in0..data_in3  in  DATA_W each  head words of input FIFOs 0..3. These are first-word-fall-through: valid whenever the matching empty_in bit is 0.
- almost_full_out  in  4  almost-full flags of output FIFOs 4..7, bit k = fifo(4+k).
- pop_in  out  4  one-hot pop to input FIFOs; combinational.
- push_out  out  4  one-hot push to output FIFOs; registered.
- data_out  out  DATA_W  word accompanying push_out; registered.
- grant  out  2  index of the last input served; registered.
- active  out  1  high when the FSM is in ACTIVE.
- req  in  1  counter read request.
- idx  in  2  counter select for req.
- cnt_out  out  CNT_W  counter read data; registered.
- cnt_valid  out  1  one-cycle strobe qualifying cnt_out.

Behaviour:
- Reset (reset=0, async): all of the following are 0:
  - pop_in, push_out, data_out, grant, cnt_out, cnt_valid, active, all counters;
  - round-robin pointer ptr (next input to consider first);
  - state = IDLE.
- Eligibility: input i is eligible iff
  - empty_in[i]=0,
  - and almost_full_out[dest_i]=0, where dest_i = data_ini[DEST_LSB+1:DEST_LSB],
  - and init=0,
  - and state != IDLE-from-reset (reset deasserted for at least one edge).
- Selection (combinational):
  - Scan i = ptr, ptr+1, ptr+2, ptr+3, mod 4; the first eligible input is the winner w.
  - pop_in = onehot(w) if any input is eligible, else 0.
  - Never more than one bit of pop_in is set.
- Registered at the rising edge after a pop of w:
  - push_out <= onehot(dest_w);
  - data_out <= data_inw, passed unmodified including the dest bits;
  - grant <= w;
  - ptr <= w+1 mod 4;
  - counter[w] increments, wrapping mod 2^CNT_W.
- With no pop that cycle: push_out <= 0; data_out, grant and ptr hold.
- Latency and throughput: pop-to-push latency is 1 cycle; throughput is 1 word per cycle.
- Output FIFO margin: push lags the almost-full sample by one cycle, so output FIFOs must assert almost_full at least 2 entries before full.
- FSM (state register):
  - IDLE: all inputs empty.
  - ACTIVE: a pop is issued this cycle.
  - STALL: some input is non-empty but none is eligible.
  - next_state is computed from the same-cycle flags: any pop -> ACTIVE; else any !empty -> STALL; else IDLE.
  - active = (state==ACTIVE), registered.
  - init=1 forces next_state = IDLE.
- init=1:
  - pop_in=0;
  - counters <= 0; ptr <= 0;
  - push_out <= 0 on the next edge;
  - data_out holds;
  - in-flight push from the previous cycle still completes.
- Counter read:
  - When req=1 at an edge: cnt_out <= counter[idx] and cnt_valid <= 1.
  - Otherwise cnt_valid <= 0 and cnt_out holds.
  - A read of an input popped in the same cycle returns the pre-increment value.
  - If req and init are both high, the read returns the pre-clear value.
- Blocked-input rule: an input whose head is blocked by almost-full does not block other inputs, so there is no head-of-line blocking across inputs.
- Reset mid-operation: all outputs return to reset values immediately (async). Any word popped in that cycle is lost; this is accepted.

Decomposition:
- Shared package/include: DATA_W, DEST_LSB, CNT_W defaults; FSM state encodings IDLE=2'd0, ACTIVE=2'd1, STALL=2'd2.
- One natural sub-module: rr_pick4, a combinational 4-way rotating priority picker.
  - Inputs: eligible[3:0], ptr[1:0].
  - Outputs: onehot[3:0], idx[1:0], any.

Test Plan:
- Reset held low with inputs toggling -> pop_in=0, push_out=0, data_out=0, grant=0, cnt_valid=0, active=0. Release, all empty -> state IDLE, no pops.
- Only input 0 non-empty, head 10'h2A5 (dest=2'b10) -> pop_in=4'b0001 same cycle; next edge push_out=4'b0100, data_out=10'h2A5, grant=0.
- All four inputs hold 3 words each, dest 0, no almost_full -> grant sequence 0,1,2,3,0,1,2,3,0,1,2,3, one per cycle. active=1 throughout, then IDLE after the 12th word.
- Backpressure: in0 head dest 1 and in1 head dest 2, almost_full_out=4'b0010, ptr=0 -> in1 popped (pop_in=4'b0010) and in0 held. With only in0 non-empty and blocked -> state STALL, pop_in=0. On almost_full release, in0 popped next cycle.
- Counters: route 33 words from input 3, then req=1, idx=3 -> next edge cnt_valid=1, cnt_out=1 (33 mod 32). Assert init -> a subsequent read gives 0 and ptr restarts at 0.
- Reset asserted mid-stream during an ACTIVE cycle -> push_out, grant and counters are 0 immediately. After release, arbitration restarts from input 0.

Source files
------------

// File: rtl/arbitro_rr_pkg.sv
// Shared constants, FSM encoding and helpers for the round-robin VC scheduler.
package arbitro_rr_pkg;

  localparam int NUM_LANES    = 4;
  localparam int DEF_DATA_W   = 10;
  localparam int DEF_DEST_LSB = 8;
  localparam int DEF_CNT_W    = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    STALL  = 2'd2
  } state_e;

  function automatic logic [3:0] onehot4(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

endpackage

// File: rtl/arbitro_rr_pick4.sv
// Combinational 4-way rotating priority picker: first eligible lane at or after ptr.
module rr_pick4
  import arbitro_rr_pkg::*;
(
  input  logic [3:0] eligible,
  input  logic [1:0] ptr,
  output logic [3:0] onehot,
  output logic [1:0] idx,
  output logic       any
);

  logic [1:0] cand;

  always_comb begin
    onehot = 4'b0000;
    idx    = 2'd0;
    any    = 1'b0;
    cand   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!any && eligible[cand]) begin
        any    = 1'b1;
        idx    = cand;
        onehot = onehot4(cand);
      end
    end
  end

endmodule

// File: rtl/arbitro_rr.sv
// Round-robin scheduler moving FWFT input VC heads to output FIFOs by dest field,
// with almost-full backpressure and per-input word counters readable via req/idx.
module arbitro_rr
  import arbitro_rr_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEST_LSB = DEF_DEST_LSB,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [3:0]        empty_in,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  input  logic [3:0]        almost_full_out,
  output logic [3:0]        pop_in,
  output logic [3:0]        push_out,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        grant,
  output logic              active,
  input  logic              req,
  input  logic [1:0]        idx,
  output logic [CNT_W-1:0]  cnt_out,
  output logic              cnt_valid
);

  logic [NUM_LANES-1:0][DATA_W-1:0] head;
  logic [NUM_LANES-1:0][1:0]        dest;
  logic [NUM_LANES-1:0][CNT_W-1:0]  cnt;
  logic [NUM_LANES-1:0]             elig;
  logic [1:0]                       ptr;
  logic [1:0]                       win;
  logic                             any_pop;
  logic                             started;
  state_e                           state, next_state;

  assign head = {data_in3, data_in2, data_in1, data_in0};

  // A lane blocked by its own output only masks itself, so no cross-input HOL blocking.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign dest[g] = head[g][DEST_LSB+1:DEST_LSB];
    assign elig[g] = !empty_in[g] && !almost_full_out[dest[g]] && !init && started;
  end

  rr_pick4 u_pick (
    .eligible (elig),
    .ptr      (ptr),
    .onehot   (pop_in),
    .idx      (win),
    .any      (any_pop)
  );

  // No pops on the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) started <= 1'b0;
    else        started <= 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      push_out <= '0;
      data_out <= '0;
      grant    <= '0;
      ptr      <= '0;
    end else begin
      push_out <= '0;
      if (any_pop) begin
        push_out <= onehot4(dest[win]);
        data_out <= head[win];
        grant    <= win;
        ptr      <= win + 2'd1;
      end
      if (init) ptr <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (init)           cnt[i] <= '0;
        else if (pop_in[i]) cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  // Read samples the pre-update counter, so same-cycle pop or init is not visible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_out   <= '0;
      cnt_valid <= 1'b0;
    end else begin
      cnt_valid <= req;
      if (req) cnt_out <= cnt[idx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = IDLE;
    if (init)           next_state = IDLE;
    else if (any_pop)   next_state = ACTIVE;
    else if (~&empty_in) next_state = STALL;
  end

  assign active = (state == ACTIVE);

endmodule

// File: tb/tb_arbitro_rr.sv
// Scoreboard bench for arbitro_rr: FWFT input FIFOs modelled as queues, pushes collected and
// compared against expected transfers queued when stimulus is loaded.
module tb_arbitro_rr;

  typedef struct packed {
    logic [3:0] push;
    logic [9:0] data;
    logic [1:0] grant;
  } xfer_t;

  logic       clk = 1'b0;
  logic       reset, init, req;
  logic [1:0] idx;
  logic [3:0] empty_in, almost_full_out;
  logic [9:0] hd [4];
  logic [3:0] pop_in, push_out;
  logic [9:0] data_out;
  logic [1:0] grant;
  logic       active, cnt_valid;
  logic [4:0] cnt_out;
  wire  [9:0] data_in0 = hd[0];
  wire  [9:0] data_in1 = hd[1];
  wire  [9:0] data_in2 = hd[2];
  wire  [9:0] data_in3 = hd[3];

  logic [9:0] fq [4][$];
  xfer_t      exp_q[$];
  xfer_t      obs_q[$];
  int         n_cmp = 0;
  int         n_err = 0;

  arbitro_rr dut (
    .clk(clk), .reset(reset), .init(init), .empty_in(empty_in),
    .data_in0(data_in0), .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3),
    .almost_full_out(almost_full_out), .pop_in(pop_in), .push_out(push_out),
    .data_out(data_out), .grant(grant), .active(active), .req(req), .idx(idx),
    .cnt_out(cnt_out), .cnt_valid(cnt_valid)
  );

  always #5 clk = ~clk;

  function automatic xfer_t mk(input logic [3:0] p, input logic [9:0] d, input logic [1:0] g);
    xfer_t x;
    x.push = p; x.data = d; x.grant = g;
    return x;
  endfunction

  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      empty_in[i] = (fq[i].size() == 0);
      hd[i]       = (fq[i].size() == 0) ? 10'h000 : fq[i][0];
    end
  endtask

  // One clock: consume whatever was popped at the edge, then record any push.
  task automatic step();
    logic [3:0] p;
    xfer_t x;
    #1;
    p = pop_in;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (p[i] && fq[i].size() > 0) void'(fq[i].pop_front());
    refresh();
    if (push_out !== 4'b0000) begin
      x = mk(push_out, data_out, grant);
      obs_q.push_back(x);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; init = 1'b0; req = 1'b0; idx = 2'd0; almost_full_out = 4'b0000;
    refresh();
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 4; i++) fq[i].push_back(10'($urandom_range(0, 1023)));
      req = c[0]; idx = 2'(c);
      almost_full_out = 4'($urandom_range(0, 15));
      refresh();
      step();
    end
    #1;
    n_cmp += 6;
    if (pop_in !== 4'b0)    begin n_err++; $display("FAIL rst_pop: got %b want 0000", pop_in); end
    if (push_out !== 4'b0)  begin n_err++; $display("FAIL rst_push: got %b want 0000", push_out); end
    if (data_out !== 10'h0) begin n_err++; $display("FAIL rst_data: got %h want 000", data_out); end
    if (grant !== 2'd0)     begin n_err++; $display("FAIL rst_grant: got %0d want 0", grant); end
    if (cnt_valid !== 1'b0) begin n_err++; $display("FAIL rst_cnt_valid: got %b want 0", cnt_valid); end
    if (active !== 1'b0)    begin n_err++; $display("FAIL rst_active: got %b want 0", active); end
    for (int i = 0; i < 4; i++) fq[i].delete();
    req = 1'b0; almost_full_out = 4'b0000;
    refresh();
    reset = 1'b1;
    step(); step();
    n_cmp += 3;
    if (pop_in !== 4'b0)   begin n_err++; $display("FAIL idle_pop: got %b want 0000", pop_in); end
    if (active !== 1'b0)   begin n_err++; $display("FAIL idle_active: got %b want 0", active); end
    if (push_out !== 4'b0) begin n_err++; $display("FAIL idle_push: got %b want 0000", push_out); end
    obs_q.delete();
  endtask

  task automatic test_single();
    xfer_t e, o;
    fq[0].push_back(10'h2A5);
    refresh();
    #1;
    n_cmp++;
    if (pop_in !== 4'b0001) begin n_err++; $display("FAIL single_pop: got %b want 0001", pop_in); end
    exp_q.push_back(mk(4'b0100, 10'h2A5, 2'd0));
    step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_err++; $display("FAIL single_xfer: got none want %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_err++; $display("FAIL single_xfer: got %h want %h", o, e); end
      end
    end
  endtask

  task automatic test_round_robin();
    xfer_t e, o;
    init = 1'b1; step(); init = 1'b0;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 4; i++) begin
        fq[i].push_back({2'b00, 8'(i * 16 + k)});
        exp_q.push_back(mk(4'b0001, {2'b00, 8'(i * 16 + k)}, 2'(i)));
      end
    refresh();
    for (int s = 0; s < 12; s++) begin
      step();
      n_cmp++;
      if (active !== 1'b1) begin n_err++; $display("FAIL rr_active%0d: got %b want 1", s, active); end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_err++; $display("FAIL rr_xfer: got none want %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_err++; $display("FAIL rr_xfer: got %h want %h", o, e); end
      end
    end
    step();
    n_cmp += 2;
    if (active !== 1'b0)   begin n_err++; $display("FAIL rr_idle_active: got %b want 0", active); end
    if (push_out !== 4'b0) begin n_err++; $display("FAIL rr_idle_push: got %b want 0000", push_out); end
  endtask

  task automatic test_backpressure();
    xfer_t e, o;
    fq[0].push_back({2'b01, 8'h11});
    fq[1].push_back({2'b10, 8'h22});
    almost_full_out = 4'b0010;
    refresh();
    #1;
    n_cmp++;
    if (pop_in !== 4'b0010) begin n_err++; $display("FAIL bp_skip_pop: got %b want 0010", pop_in); end
    exp_q.push_back(mk(4'b0100, {2'b10, 8'h22}, 2'd1));
    step();
    #1;
    n_cmp++;
    if (pop_in !== 4'b0000) begin n_err++; $display("FAIL bp_blocked_pop: got %b want 0000", pop_in); end
    step();
    n_cmp += 2;
    if (active !== 1'b0)   begin n_err++; $display("FAIL bp_stall_active: got %b want 0", active); end
    if (push_out !== 4'b0) begin n_err++; $display("FAIL bp_stall_push: got %b want 0000", push_out); end
    almost_full_out = 4'b0000;
    #1;
    n_cmp++;
    if (pop_in !== 4'b0001) begin n_err++; $display("FAIL bp_release_pop: got %b want 0001", pop_in); end
    exp_q.push_back(mk(4'b0010, {2'b01, 8'h11}, 2'd0));
    step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_err++; $display("FAIL bp_xfer: got none want %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_err++; $display("FAIL bp_xfer: got %h want %h", o, e); end
      end
    end
  endtask

  task automatic test_counters();
    xfer_t e, o;
    init = 1'b1; step(); init = 1'b0;
    for (int k = 0; k < 33; k++) begin
      fq[3].push_back({2'b11, 8'(k)});
      exp_q.push_back(mk(4'b1000, {2'b11, 8'(k)}, 2'd3));
    end
    refresh();
    for (int s = 0; s < 33; s++) step();
    req = 1'b1; idx = 2'd3; step(); req = 1'b0;
    n_cmp += 2;
    if (cnt_valid !== 1'b1) begin n_err++; $display("FAIL cnt_wrap_valid: got %b want 1", cnt_valid); end
    if (cnt_out !== 5'd1)   begin n_err++; $display("FAIL cnt_wrap_val: got %0d want 1", cnt_out); end
    step();
    n_cmp += 2;
    if (cnt_valid !== 1'b0) begin n_err++; $display("FAIL cnt_strobe: got %b want 0", cnt_valid); end
    if (cnt_out !== 5'd1)   begin n_err++; $display("FAIL cnt_hold: got %0d want 1", cnt_out); end
    // Move ptr to 2 so the init restart of ptr is observable.
    fq[1].push_back({2'b00, 8'h55});
    exp_q.push_back(mk(4'b0001, {2'b00, 8'h55}, 2'd1));
    refresh();
    step();
    init = 1'b1; req = 1'b1; idx = 2'd3; step(); init = 1'b0;
    n_cmp++;
    if (cnt_out !== 5'd1) begin n_err++; $display("FAIL cnt_preclear: got %0d want 1", cnt_out); end
    step(); req = 1'b0;
    n_cmp++;
    if (cnt_out !== 5'd0) begin n_err++; $display("FAIL cnt_cleared: got %0d want 0", cnt_out); end
    fq[2].push_back({2'b00, 8'h77});
    fq[0].push_back({2'b00, 8'h66});
    exp_q.push_back(mk(4'b0001, {2'b00, 8'h66}, 2'd0));
    exp_q.push_back(mk(4'b0001, {2'b00, 8'h77}, 2'd2));
    refresh();
    step(); step();
    fq[3].push_back({2'b11, 8'h99});
    exp_q.push_back(mk(4'b1000, {2'b11, 8'h99}, 2'd3));
    refresh();
    req = 1'b1; idx = 2'd3; step();
    n_cmp++;
    if (cnt_out !== 5'd0) begin n_err++; $display("FAIL cnt_same_cycle: got %0d want 0", cnt_out); end
    step(); req = 1'b0;
    n_cmp++;
    if (cnt_out !== 5'd1) begin n_err++; $display("FAIL cnt_after_pop: got %0d want 1", cnt_out); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_err++; $display("FAIL cnt_xfer: got none want %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_err++; $display("FAIL cnt_xfer: got %h want %h", o, e); end
      end
    end
  endtask

  task automatic test_reset_mid();
    xfer_t e, o;
    int budget;
    init = 1'b1; step(); init = 1'b0;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) fq[i].push_back({2'b00, 8'(i * 16 + k)});
    exp_q.push_back(mk(4'b0001, {2'b00, 8'h00}, 2'd0));
    exp_q.push_back(mk(4'b0001, {2'b00, 8'h10}, 2'd1));
    refresh();
    step(); step();
    n_cmp++;
    if (active !== 1'b1) begin n_err++; $display("FAIL mid_pre_active: got %b want 1", active); end
    #2;
    reset = 1'b0;
    #1;
    n_cmp += 4;
    if (push_out !== 4'b0) begin n_err++; $display("FAIL mid_push: got %b want 0000", push_out); end
    if (grant !== 2'd0)    begin n_err++; $display("FAIL mid_grant: got %0d want 0", grant); end
    if (data_out !== 10'h0) begin n_err++; $display("FAIL mid_data: got %h want 000", data_out); end
    if (active !== 1'b0)   begin n_err++; $display("FAIL mid_active: got %b want 0", active); end
    step();
    reset = 1'b1;
    #1;
    n_cmp++;
    if (pop_in !== 4'b0) begin n_err++; $display("FAIL mid_first_edge_pop: got %b want 0000", pop_in); end
    req = 1'b1; idx = 2'd0; step(); req = 1'b0;
    n_cmp++;
    if (cnt_out !== 5'd0) begin n_err++; $display("FAIL mid_cnt_cleared: got %0d want 0", cnt_out); end
    exp_q.push_back(mk(4'b0001, {2'b00, 8'h01}, 2'd0));
    exp_q.push_back(mk(4'b0001, {2'b00, 8'h11}, 2'd1));
    exp_q.push_back(mk(4'b0001, {2'b00, 8'h20}, 2'd2));
    exp_q.push_back(mk(4'b0001, {2'b00, 8'h30}, 2'd3));
    for (int s = 0; s < 4; s++) step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_err++; $display("FAIL mid_xfer: got none want %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_err++; $display("FAIL mid_xfer: got %h want %h", o, e); end
      end
    end
    budget = 0;
    while ((fq[0].size() + fq[1].size() + fq[2].size() + fq[3].size()) > 0 && budget < 40) begin
      step(); budget++;
    end
    n_cmp++;
    if (budget >= 40) begin n_err++; $display("FAIL mid_drain: got timeout want empty inputs"); end
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_counters();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
